// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver: hex decode, blanking, dp, blink,
// with a shadow register set that commits to the displayed set only at frame boundaries.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 64,
   localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1,
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   digits_in,
   input  logic [NUM_DIGITS-1:0]     digit_en_in,
   input  logic [NUM_DIGITS-1:0]     blink_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   output logic                      load_ack,
   output logic [6:0]                segments,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     anode_active,
   output logic [SW-1:0]             scan_idx,
   output logic                      frame_tick
);

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b0000001;
         4'h1: hex7 = 7'b1001111;
         4'h2: hex7 = 7'b0010010;
         4'h3: hex7 = 7'b0000110;
         4'h4: hex7 = 7'b1001100;
         4'h5: hex7 = 7'b0100100;
         4'h6: hex7 = 7'b0100000;
         4'h7: hex7 = 7'b0001111;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0000100;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b1100000;
         4'hC: hex7 = 7'b0110001;
         4'hD: hex7 = 7'b1000010;
         4'hE: hex7 = 7'b0110000;
         default: hex7 = 7'b0111000;
      endcase
   endfunction

   logic [PW-1:0]             presc_q, presc_d;
   logic [SW-1:0]             scan_q, scan_d;
   logic [FW-1:0]             fcnt_q, fcnt_d;
   logic                      phase_q, phase_d;
   logic                      ft_q, ft_d;
   logic                      pend_q, pend_d;
   logic [4*NUM_DIGITS-1:0]   sh_dig_q, act_dig_q, act_dig_d;
   logic [NUM_DIGITS-1:0]     sh_en_q, sh_blk_q, sh_dp_q;
   logic [NUM_DIGITS-1:0]     act_en_q, act_blk_q, act_dp_q;
   logic [NUM_DIGITS-1:0]     act_en_d, act_blk_d, act_dp_d;
   logic [6:0]                seg_q, seg_d;
   logic                      dp_q, dp_d;
   logic [NUM_DIGITS-1:0]     an_q, an_d;
   logic                      presc_end, commit, blank;
   logic                      en_sel, blk_sel, dp_sel;
   logic [3:0]                nib_sel;

   always_comb begin
      presc_end = (presc_q == PW'(REFRESH_DIV - 1));
      presc_d   = presc_end ? '0 : presc_q + 1'b1;
      scan_d    = scan_q;
      if (presc_end)
         scan_d = (scan_q == SW'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
      ft_d = presc_end && (scan_q == SW'(NUM_DIGITS - 1));

      // Commit and blink-phase update share the frame_tick cycle; the decode below
      // looks at their next-state values so digit 0 of the new frame is already current.
      commit    = ft_q & pend_q;
      act_dig_d = commit ? sh_dig_q : act_dig_q;
      act_en_d  = commit ? sh_en_q  : act_en_q;
      act_blk_d = commit ? sh_blk_q : act_blk_q;
      act_dp_d  = commit ? sh_dp_q  : act_dp_q;
      pend_d    = load | (pend_q & ~commit);

      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      if (ft_q) begin
         if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end

      nib_sel = '0;
      en_sel  = 1'b0;
      blk_sel = 1'b0;
      dp_sel  = 1'b0;
      an_d    = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scan_q == SW'(i)) begin
            nib_sel = act_dig_d[4*i +: 4];
            en_sel  = act_en_d[i];
            blk_sel = act_blk_d[i];
            dp_sel  = act_dp_d[i];
            an_d[i] = 1'b0;
         end
      end
      blank = ~en_sel | (blk_sel & phase_d);
      seg_d = blank ? 7'h7F : hex7(nib_sel);
      dp_d  = blank ? 1'b1 : ~dp_sel;
      if (blank) an_d = '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q   <= '0;
         scan_q    <= '0;
         fcnt_q    <= '0;
         phase_q   <= 1'b0;
         ft_q      <= 1'b0;
         pend_q    <= 1'b0;
         sh_dig_q  <= '0;
         sh_en_q   <= '0;
         sh_blk_q  <= '0;
         sh_dp_q   <= '0;
         act_dig_q <= '0;
         act_en_q  <= '0;
         act_blk_q <= '0;
         act_dp_q  <= '0;
         seg_q     <= 7'h7F;
         dp_q      <= 1'b1;
         an_q      <= '1;
      end else begin
         presc_q   <= presc_d;
         scan_q    <= scan_d;
         fcnt_q    <= fcnt_d;
         phase_q   <= phase_d;
         ft_q      <= ft_d;
         pend_q    <= pend_d;
         act_dig_q <= act_dig_d;
         act_en_q  <= act_en_d;
         act_blk_q <= act_blk_d;
         act_dp_q  <= act_dp_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
         if (load) begin
            sh_dig_q <= digits_in;
            sh_en_q  <= digit_en_in;
            sh_blk_q <= blink_in;
            sh_dp_q  <= dp_in;
         end
      end
   end

   assign load_ack     = commit;
   assign frame_tick   = ft_q;
   assign scan_idx     = scan_q;
   assign segments     = seg_q;
   assign dp           = dp_q;
   assign anode_active = an_q;

endmodule
